// File: rtl/wb_cdma_master.sv
// wb_cdma_master: single-channel byte-copy DMA engine, classic Wishbone master
// on the 8-bit scratchpad bus. Copies len bytes from src_addr to dst_addr,
// one read then one write per byte, with a one-cycle STB-low gap after every
// access so a registered ACK from the slave is never counted twice.
//
// Optional feature macro: CDMA_TIMEOUT_EN
//   defined   - a strobe waiting TO_CYC cycles without ACK aborts the
//               transfer, sets the sticky err flag and goes to DONE.
//   undefined - no watchdog is built, err is tied low and the engine waits
//               indefinitely for ACK.
module wb_cdma_master #(
    parameter int AWID   = 10,
    parameter int LWID   = AWID + 1,
    parameter int TO_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,        // asynchronous, active-low
    input  logic            start,
    input  logic [AWID-1:0] src_addr,
    input  logic [AWID-1:0] dst_addr,
    input  logic [LWID-1:0] len,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [AWID-1:0] WB_ADRo,
    output logic [7:0]      WB_DATo,
    input  logic [7:0]      WB_DATi,
    output logic            WB_WEo,
    output logic            WB_CYCo,
    output logic            WB_STBo,
    input  logic            WB_ACKi
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RGAP,
        WR,
        WGAP,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AWID-1:0] src_q, src_d;
    logic [AWID-1:0] dst_q, dst_d;
    logic [LWID-1:0] cnt_q, cnt_d;
    logic [7:0]      buf_q, buf_d;
    logic            cyc_d, stb_d, we_d;
    logic [AWID-1:0] adr_d;
    logic            ack;
    logic            to_hit;

    // An ACK only counts while our own strobe is up.
    assign ack = WB_ACKi & WB_STBo;

`ifdef CDMA_TIMEOUT_EN
    localparam int TOW = $clog2(TO_CYC + 1);

    logic [TOW-1:0] to_cnt_q;
    logic           err_q;

    // The last un-ACKed strobe cycle before the watchdog fires.
    assign to_hit = WB_STBo & ~WB_ACKi & (to_cnt_q == TOW'(TO_CYC - 1));
    assign err    = err_q;

    // Watchdog: counts consecutive strobe cycles without ACK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (WB_STBo && !WB_ACKi && !to_hit) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end

    // Sticky error flag: set by the watchdog, cleared by an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            err_q <= 1'b0;
        end else if (to_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_to;

    assign to_hit    = 1'b0;
    assign err       = 1'b0;
    // Keeps the watchdog limit referenced when the watchdog is not built.
    assign unused_to = ^TO_CYC;
`endif

    // Next-state, datapath and next-output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    cnt_d   = len;
                    state_d = (len == '0) ? DONE : RD;
                end
            end
            RD: begin
                if (to_hit) begin
                    state_d = DONE;
                end else if (ack) begin
                    buf_d   = WB_DATi;
                    src_d   = src_q + 1'b1;
                    state_d = RGAP;
                end
            end
            RGAP: state_d = WR;
            WR: begin
                if (to_hit) begin
                    state_d = DONE;
                end else if (ack) begin
                    dst_d   = dst_q + 1'b1;
                    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
                    state_d = WGAP;
                end
            end
            WGAP:    state_d = (cnt_q == '0) ? DONE : RD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus outputs are decoded from the next state so they can be registered.
        cyc_d = state_d inside {RD, RGAP, WR, WGAP};
        stb_d = state_d inside {RD, WR};
        we_d  = (state_d == WR);
        adr_d = (state_d == WR) ? dst_d : src_d;
    end

    // State, datapath and registered bus/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            WB_CYCo <= 1'b0;
            WB_STBo <= 1'b0;
            WB_WEo  <= 1'b0;
            WB_ADRo <= '0;
            WB_DATo <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            WB_CYCo <= cyc_d;
            WB_STBo <= stb_d;
            WB_WEo  <= we_d;
            WB_ADRo <= adr_d;
            WB_DATo <= buf_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_wb_cdma_master.sv
// tb_wb_cdma_master: directed bench for wb_cdma_master against a behavioural
// scratchpad slave with a registered ACK and programmable wait states.
// Cycle 0 is the cycle in which start is driven high.
module tb_wb_cdma_master;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] src_addr, dst_addr;
    logic [10:0] len;
    logic       busy, done, err;
    logic [9:0] WB_ADRo;
    logic [7:0] WB_DATo, WB_DATi;
    logic       WB_WEo, WB_CYCo, WB_STBo, WB_ACKi;

    wb_cdma_master #(.AWID(10), .LWID(11), .TO_CYC(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .WB_ADRo  (WB_ADRo),
        .WB_DATo  (WB_DATo),
        .WB_DATi  (WB_DATi),
        .WB_WEo   (WB_WEo),
        .WB_CYCo  (WB_CYCo),
        .WB_STBo  (WB_STBo),
        .WB_ACKi  (WB_ACKi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scratchpad slave model
    logic [7:0] mem [0:1023];
    logic [9:0] rd_log[$];
    logic [9:0] wr_log[$];
    int         waits;
    bit         no_ack;
    int         wcnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_ACKi <= 1'b0;
            WB_DATi <= 8'h00;
            wcnt    <= 0;
        end else if (WB_CYCo && WB_STBo && !WB_ACKi && !no_ack) begin
            if (wcnt == waits) begin
                WB_ACKi <= 1'b1;
                wcnt    <= 0;
                if (WB_WEo) begin
                    mem[WB_ADRo] = WB_DATo;
                    wr_log.push_back(WB_ADRo);
                end else begin
                    WB_DATi <= mem[WB_ADRo];
                    rd_log.push_back(WB_ADRo);
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            WB_ACKi <= 1'b0;
            if (!WB_STBo) wcnt <= 0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one transfer; optionally re-pulses start (other operands) in cycle inj.
    task automatic run_xfer(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n,
                            input int inj, output int done_cyc, output int busy_cnt,
                            output bit cyc_seen);
        rd_log.delete();
        wr_log.delete();
        @(posedge clk); #1;
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        done_cyc = -1; busy_cnt = 0; cyc_seen = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == inj) begin
                src_addr = 10'h3FE; dst_addr = 10'h280; len = 11'd1; start = 1'b1;
            end
            if (busy) busy_cnt++;
            if (WB_CYCo) cyc_seen = 1'b1;
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        start = 1'b0;
        if (done_cyc < 0) check("xfer_bound", 0, 1);
    endtask

    int         dc, bc;
    bit         cs;
    logic [9:0] wrap_exp [4];
    logic [7:0] wrap_dat [4];

    initial begin
        rst = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        waits = 0; no_ack = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h010] = 8'h11; mem[10'h011] = 8'h22; mem[10'h012] = 8'h33; mem[10'h013] = 8'h44;
        mem[10'h3FE] = 8'hA1; mem[10'h3FF] = 8'hB2; mem[10'h000] = 8'hC3; mem[10'h001] = 8'hD4;
        mem[10'h300] = 8'hA5; mem[10'h280] = 8'h5A;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_bus", {done, err, WB_CYCo, WB_STBo, WB_WEo}, 0);
        check("rst_adr_dat", {WB_ADRo, WB_DATo}, 0);
        rst = 1'b1;

        // Basic 4-byte copy
        run_xfer(10'h010, 10'h200, 11'd4, -1, dc, bc, cs);
        check("t1_done_cyc", dc, 25);
        check("t1_busy_cnt", bc, 25);
        check("t1_err", err, 0);
        @(posedge clk); #1;
        check("t1_idle_busy", busy, 0);
        check("t1_done_pulse", done, 0);
        check("t1_data", {mem[10'h200], mem[10'h201], mem[10'h202], mem[10'h203]}, 32'h11223344);

        // Zero length: no bus cycle, memory untouched
        run_xfer(10'h010, 10'h300, 11'd0, -1, dc, bc, cs);
        check("t2_done_cyc", dc, 1);
        check("t2_cyc_seen", cs, 0);
        check("t2_mem", mem[10'h300], 8'hA5);
        check("t2_accesses", rd_log.size() + wr_log.size(), 0);

        // Source pointer wraps from 0x3FF to 0x000
        run_xfer(10'h3FE, 10'h100, 11'd4, -1, dc, bc, cs);
        wrap_exp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        wrap_dat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        check("t3_rd_count", rd_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rd_log.size()) check($sformatf("t3_rd_adr%0d", i), rd_log[i], wrap_exp[i]);
            check($sformatf("t3_data%0d", i), mem[10'h100 + i], wrap_dat[i]);
        end

        // Two wait states per access
        waits = 2;
        run_xfer(10'h010, 10'h220, 11'd2, -1, dc, bc, cs);
        check("t4_done_cyc", dc, 21);
        check("t4_data", {mem[10'h220], mem[10'h221]}, 16'h1122);
        check("t4_rd_count", rd_log.size(), 2);
        check("t4_wr_count", wr_log.size(), 2);
        waits = 0;

        // Re-start in cycle 5 is ignored
        run_xfer(10'h010, 10'h240, 11'd4, 5, dc, bc, cs);
        check("t5_done_cyc", dc, 25);
        check("t5_data", {mem[10'h240], mem[10'h241], mem[10'h242], mem[10'h243]}, 32'h11223344);
        check("t5_wr_count", wr_log.size(), 4);
        if (rd_log.size() == 4) begin
            check("t5_rd_first", rd_log[0], 10'h010);
            check("t5_rd_last", rd_log[3], 10'h013);
        end else begin
            check("t5_rd_count", rd_log.size(), 4);
        end
        check("t5_ignored_dst", mem[10'h280], 8'h5A);

`ifdef CDMA_TIMEOUT_EN
        // Slave never acknowledges
        no_ack = 1'b1;
        run_xfer(10'h010, 10'h2C0, 11'd3, -1, dc, bc, cs);
        check("t6_done_cyc", dc, 9);
        check("t6_err", err, 1);
        check("t6_cyc_in_done", WB_CYCo, 0);
        @(posedge clk); #1;
        check("t6_cyc_after", WB_CYCo, 0);
        check("t6_wr_count", wr_log.size(), 0);
        no_ack = 1'b0;
        run_xfer(10'h010, 10'h2C0, 11'd1, -1, dc, bc, cs);
        check("t6_err_cleared", err, 0);
        check("t6_retry_done", dc, 7);
`endif

        // Asynchronous reset while in WR
        @(posedge clk); #1;
        src_addr = 10'h010; dst_addr = 10'h300; len = 11'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t7_in_wr", {WB_CYCo, WB_STBo, WB_WEo}, 3'b111);
        #2 rst = 1'b0;
        #1;
        check("t7_rst_status", {busy, done, err}, 0);
        check("t7_rst_bus", {WB_CYCo, WB_STBo, WB_WEo}, 0);
        check("t7_rst_adr_dat", {WB_ADRo, WB_DATo}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t7_idle_after", {busy, WB_CYCo}, 0);
        run_xfer(10'h012, 10'h260, 11'd1, -1, dc, bc, cs);
        check("t7_recover_done", dc, 7);
        check("t7_recover_data", mem[10'h260], 8'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_cdma_master.md
# wb_cdma_master

Single-channel byte-copy DMA engine acting as a classic Wishbone master on the 8-bit scratchpad bus. It copies `len` bytes from a source address to a destination address, one read then one write per byte, without a CPU in the loop. It attaches to the same 8-bit Wishbone fabric as the scratchpad memory and is compatible with that memory's one-cycle registered-ACK response.

## Interface
- `AWID`, 10, width of Wishbone address, source/destination pointers
- `LWID`, AWID+1, width of the transfer length; allows lengths up to 2^AWID
- `TO_CYC`, 255, maximum cycles a strobe waits for ACK; used only with the timeout feature
- `clk` in 1 system clock; all logic is on the rising edge
- `rst` in 1 reset, asynchronous, active-low
- `start` in 1 one-cycle request; sampled only in IDLE
- `src_addr` in AWID first read address, latched on accepted `start`
- `dst_addr` in AWID first write address, latched on accepted `start`
- `len` in LWID byte count, latched on accepted `start`
- `busy` out 1 high whenever state is not IDLE
- `done` out 1 one-cycle pulse at end of transfer (normal or error)
- `err` out 1 sticky timeout flag, cleared on the next accepted `start`
- `WB_ADRo` out AWID bus address
- `WB_DATo` out 8 write data
- `WB_DATi` in 8 read data
- `WB_WEo` out 1 write enable
- `WB_CYCo` out 1 cycle valid, held high for the whole transfer
- `WB_STBo` out 1 strobe
- `WB_ACKi` in 1 slave acknowledge

## Operation
- FSM states are IDLE, RD, RGAP, WR, WGAP, DONE. All bus outputs are registered.
- IDLE: `start`=1 latches the pointers and count. If `len`=0, the next state is DONE with no bus cycle. Otherwise the next state is RD.
- RD: CYC=STB=1, WE=0, ADR=src pointer. `WB_ACKi` is sampled only while STB=1. On ACK, `WB_DATi` is captured into the byte buffer, the src pointer increments, and the next state is RGAP.
- RGAP: CYC=1, STB=0, for one cycle. This guarantees a stale registered ACK is never taken as the next ACK. The next state is WR.
- WR: CYC=STB=WE=1, ADR=dst pointer, `WB_DATo`=buffer. On ACK, the dst pointer increments, the count decrements, and the next state is WGAP.
- WGAP: CYC=1, STB=WE=0, for one cycle. The next state is DONE if the count is 0, else RD.
- DONE: CYC=STB=WE=0, `done`=1, for one cycle. The next state is IDLE.
- Pointers increment modulo 2^AWID, so addresses wrap silently from all-ones to 0. The count never underflows.
- `start` outside IDLE is ignored and has no effect on the latched values.
- Reset values are `busy`=`done`=`err`=0, CYC=STB=WE=0, ADR=0, `WB_DATo`=0, and state IDLE.
- Reset asserted mid-transfer forces all of the above immediately (asynchronously). The transfer is abandoned; a partial copy is acceptable.

## Timing
- `start` high in cycle 0 gives RD in cycle 1.
- With a zero-wait slave (ACK in the second STB cycle), each byte takes 6 cycles: RD×2, RGAP, WR×2, WGAP.
- For N≥1 bytes, DONE is cycle 6N+1 and IDLE is cycle 6N+2.
- `busy` is high for cycles 1..6N+1.
- With `len`=0, DONE is cycle 1.
- Each wait state on the slave adds one cycle per access.
- The earliest accepted re-`start` is in the cycle after DONE.

## Configuration
- `CDMA_TIMEOUT_EN` defined:
  - A counter counts consecutive STB=1 cycles without ACK. It resets when STB is low and on every ACK.
  - When the count reaches `TO_CYC`, the engine sets `err`=1 and goes straight to DONE. CYC/STB/WE drop in the DONE cycle and no further accesses are made.
- `CDMA_TIMEOUT_EN` undefined:
  - No counter is built, `err` is tied to 0, and the engine waits indefinitely for ACK.

## Test plan
- Scratchpad pre-loaded with 0x11,0x22,0x33,0x44 at 0x010; start with src=0x010, dst=0x200, len=4 -> 0x200..0x203 read back 0x11..0x44; `done` pulses in cycle 25; `busy` is high in cycles 1..25; `err`=0.
- len=0 -> `done` in cycle 1; CYC never asserted; memory unchanged.
- src=0x3FE, dst=0x100, len=4 -> reads occur at addresses 0x3FE,0x3FF,0x000,0x001 in order; 0x100..0x103 receive those bytes.
- Slave inserting 2 wait states per access, len=2 -> data copied correctly; `done` in cycle 6·2+4·2+1=21; no double write or read is caused by a stale ACK in a gap cycle.
- `start` pulsed again in cycle 5 of a len=4 transfer with different addresses -> ignored; the original copy completes unaltered.
- With `CDMA_TIMEOUT_EN` and TO_CYC=8, a slave that never ACKs -> `err`=1 and `done` pulse after 8 STB cycles, CYC low afterwards; the next `start` clears `err`.
- `rst` asserted low mid-WR -> all outputs 0 in the same cycle; state IDLE after release.
